sw_conditioner: RTL and testbench

Input conditioning stage for the 3-bit slide-switch bank that drives the mode/LED state machine. The block synchronises the raw asynchronous switch levels into `clk`, debounces the whole 3-bit code as one vector, and presents a clean registered code `sw_out` plus a one-cycle change strobe. The downstream FSM's `sw` input connects directly to `sw_out`. The downstream FSM then sees only stable, glitch-free codes.

---
 rtl/sw_conditioner.sv | 85 ++++++++
 tb/tb_sw_conditioner.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sw_conditioner.sv
// Synchronise, debounce and register the 3-bit switch code; sw_out/sw_chg land DB_CYCLES+3 edges after a held change.
// Optional SW_CODE_FILTER_EN rejects codes the downstream FSM does not decode (flagged on sw_illegal).
module sw_conditioner #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_raw,
    output logic [2:0] sw_out,
    output logic       sw_chg,
    output logic       busy,
    output logic       sw_illegal
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    cand;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Any movement of the synchronised code restarts the hold count; the count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand <= 3'b000;
            cnt  <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign stable = (sync2 == cand) && (cnt == CNT_MAX);

`ifdef SW_CODE_FILTER_EN
    logic legal;
    assign legal = (cand == 3'b000) || (cand == 3'b001) || (cand == 3'b010) ||
                   (cand == 3'b100) || (cand == 3'b111);
    assign accept = stable && (cand != sw_out) && legal;

    // Flag holds until the candidate moves, i.e. the same cycle cand reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_illegal <= 1'b0;
        end else if (sync2 != cand) begin
            sw_illegal <= 1'b0;
        end else if (stable && (cand != sw_out) && !legal) begin
            sw_illegal <= 1'b1;
        end
    end
`else
    assign accept     = stable && (cand != sw_out);
    assign sw_illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_out <= 3'b000;
            sw_chg <= 1'b0;
        end else begin
            sw_chg <= accept;
            if (accept) begin
                sw_out <= cand;
            end
        end
    end

    assign busy = (cand != sw_out);

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed stimulus with a pulse scoreboard: each expected acceptance (code, edge) is queued and popped on sw_chg.
module tb_sw_conditioner;

    localparam int DB = 8;
    localparam int LAT = DB + 3;

    logic       clk;
    logic       rst;
    logic [2:0] sw_raw;
    logic [2:0] sw_out;
    logic       sw_chg;
    logic       busy;
    logic       sw_illegal;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_code[$];
    int exp_cyc[$];

    sw_conditioner #(.DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .sw_out     (sw_out),
        .sw_chg     (sw_chg),
        .busy       (busy),
        .sw_illegal (sw_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a new code at a negedge and queue the acceptance it must produce.
    task automatic step_exp(input logic [2:0] code);
        sw_raw = code;
        exp_code.push_back(int'(code));
        exp_cyc.push_back(cyc + LAT);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && sw_chg) begin
            if (exp_code.size() == 0) begin
                chk("unexpected_pulse", int'(sw_out), -1);
            end else begin
                chk("pulse_code", int'(sw_out), exp_code.pop_front());
                chk("pulse_edge", cyc, exp_cyc.pop_front());
            end
        end
    end

    logic [2:0] seq [5];
    logic [2:0] rcode;

    initial begin
        seq = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111};
`ifdef SW_CODE_FILTER_EN
        rcode = 3'b100;
`else
        rcode = 3'b101;
`endif
        rst    = 1'b1;
        sw_raw = 3'b000;
        wait_n(3);
        chk("rst_sw_out", int'(sw_out), 0);
        chk("rst_sw_chg", int'(sw_chg), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_illegal", int'(sw_illegal), 0);
        rst = 1'b0;
        wait_n(3);

        // Clean change 000 -> 001
        step_exp(3'b001);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("clean_busy", int'(busy), (i >= 3 && i <= 10) ? 1 : 0);
            chk("clean_out", int'(sw_out), (i >= 11) ? 1 : 0);
        end

        // Bounce 001 <-> 000 every 3 cycles, then settle on 010
        for (int k = 0; k < 10; k++) begin
            sw_raw = (k % 2 == 0) ? 3'b000 : 3'b001;
            wait_n(3);
            chk("bounce_out", int'(sw_out), 1);
        end
        step_exp(3'b010);
        wait_n(14);
        chk("bounce_final", int'(sw_out), 2);

        // Excursion to 100 for 5 cycles, then back to the accepted code
        sw_raw = 3'b100;
        wait_n(5);
        chk("return_busy_mid", int'(busy), 1);
        sw_raw = 3'b010;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("return_out", int'(sw_out), 2);
        end
        chk("return_busy_end", int'(busy), 0);

        // Back-to-back legal codes, 12 cycles each
        for (int i = 0; i < 5; i++) begin
            step_exp(seq[i]);
            wait_n(12);
            chk("b2b_out", int'(sw_out), int'(seq[i]));
        end

`ifdef SW_CODE_FILTER_EN
        step_exp(3'b000);
        wait_n(12);
        sw_raw = 3'b011;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("filt_illegal", int'(sw_illegal), (i >= 11) ? 1 : 0);
            chk("filt_out", int'(sw_out), 0);
        end
        step_exp(3'b111);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("filt_clear", int'(sw_illegal), (i < 3) ? 1 : 0);
        end
        chk("filt_final", int'(sw_out), 7);
`endif

        // Asynchronous reset mid-count
        sw_raw = rcode;
        wait_n(5);
        chk("prerst_busy", int'(busy), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_sw_out", int'(sw_out), 0);
        chk("arst_sw_chg", int'(sw_chg), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_illegal", int'(sw_illegal), 0);
        wait_n(2);
        rst = 1'b0;
        exp_code.push_back(int'(rcode));
        exp_cyc.push_back(cyc + LAT);
        wait_n(15);
        chk("postrst_out", int'(sw_out), int'(rcode));
        chk("pending_pulses", exp_code.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
